// File: rtl/approx_err_stat.sv
`default_nettype none
// ============================================================================
// Module      : approx_err_stat
// Description : Error statistics for approximate vs exact products: error
//               count, sum of error distance, signed error sum, max distance.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_err_stat #(
    parameter int PW = 16,
    parameter int NW = 16,
    parameter int AW = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n_samples,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] prod_apx,
    input  logic [PW-1:0] prod_exact,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] sample_cnt,
    output logic [NW-1:0] err_cnt,
    output logic [AW-1:0] sum_ed,
    output logic [AW-1:0] sum_err,
    output logic [PW-1:0] max_ed
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [NW-1:0] c_cnt_one = {{(NW-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_sample_cnt;
    logic [NW-1:0] r_err_cnt;
    logic [AW-1:0] r_sum_ed;
    logic [AW-1:0] r_sum_err;
    logic [PW-1:0] r_max_ed;

    // Stage-1 registers: difference, its magnitude and nonzero flag
    logic          r_s1_valid;
    logic [PW:0]   r_d;
    logic [PW-1:0] r_ed;
    logic          r_ne;

    logic          w_start_ok;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;
    logic [PW:0]   w_d;
    logic [PW:0]   w_neg_d;
    logic [PW-1:0] w_ed;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_in_ready = (r_state == S_RUN) && (r_sample_cnt < r_n);
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = w_accept && ((r_sample_cnt + c_cnt_one) == r_n);

    // The magnitude of a (PW+1)-bit difference of two PW-bit values fits in PW bits
    assign w_d     = {1'b0, prod_apx} - {1'b0, prod_exact};
    assign w_neg_d = -w_d;
    assign w_ed    = w_d[PW] ? w_neg_d[PW-1:0] : w_d[PW-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (n_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_sum_err    <= '0;
            r_max_ed     <= '0;
            r_s1_valid   <= 1'b0;
            r_d          <= '0;
            r_ed         <= '0;
            r_ne         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_n          <= n_samples;
                r_sample_cnt <= '0;
                r_err_cnt    <= '0;
                r_sum_ed     <= '0;
                r_sum_err    <= '0;
                r_max_ed     <= '0;
                r_s1_valid   <= 1'b0;
            end else begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_sample_cnt <= r_sample_cnt + c_cnt_one;
                    r_d          <= w_d;
                    r_ed         <= w_ed;
                    r_ne         <= |w_d;
                end
                if (r_s1_valid) begin
                    r_sum_ed  <= r_sum_ed + {{(AW-PW){1'b0}}, r_ed};
                    r_sum_err <= r_sum_err + {{(AW-PW-1){r_d[PW]}}, r_d};
                    r_err_cnt <= r_err_cnt + {{(NW-1){1'b0}}, r_ne};
                    if (r_ed > r_max_ed) begin
                        r_max_ed <= r_ed;
                    end
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;
    assign sum_ed     = r_sum_ed;
    assign sum_err    = r_sum_err;
    assign max_ed     = r_max_ed;

endmodule
`default_nettype wire

// File: tb/tb_approx_err_stat.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_err_stat
// Description : Directed self-checking bench for approx_err_stat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_err_stat;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n_samples;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] prod_apx;
    logic [15:0] prod_exact;
    logic        busy;
    logic        done;
    logic [15:0] sample_cnt;
    logic [15:0] err_cnt;
    logic [39:0] sum_ed;
    logic [39:0] sum_err;
    logic [15:0] max_ed;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    approx_err_stat dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_samples (n_samples),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod_apx  (prod_apx),
        .prod_exact(prod_exact),
        .busy      (busy),
        .done      (done),
        .sample_cnt(sample_cnt),
        .err_cnt   (err_cnt),
        .sum_ed    (sum_ed),
        .sum_err   (sum_err),
        .max_ed    (max_ed)
    );

    // Inputs change on the falling edge; one call spans one rising edge.
    task automatic start_run(input logic [15:0] n);
        @(negedge clk);
        start     = 1'b1;
        n_samples = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; n_samples = '0; in_valid = 1'b0;
        prod_apx = '0; prod_exact = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 000", {in_ready, busy, done});
        end
        checks++;
        if ({sample_cnt, err_cnt, sum_ed, sum_err, max_ed} !== '0) begin
            fails++; $display("FAIL reset_stats: got cnt=%0d err=%0d sed=%0d serr=%0d max=%0d expected all 0",
                              sample_cnt, err_cnt, sum_ed, sum_err, max_ed);
        end
    endtask

    task automatic test_full_rate;
        logic [15:0] apx [4] = '{16'd100, 16'd96, 16'd110, 16'd0};
        logic [15:0] exa [4] = '{16'd100, 16'd100, 16'd100, 16'd65535};
        logic [39:0] exp_err = -40'sd65529;
        int lat;
        int cyc;
        start_run(16'd4);
        lat = 1;
        checks++;
        if ({in_ready, busy} !== 2'b11) begin
            fails++; $display("FAIL fr_run_entry: got ready/busy=%b expected 11", {in_ready, busy});
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; prod_apx = apx[i]; prod_exact = exa[i];
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, done, sample_cnt} !== {3'b010, 16'd4}) begin
            fails++; $display("FAIL fr_drain: got ready=%b busy=%b done=%b cnt=%0d expected 0 1 0 4",
                              in_ready, busy, done, sample_cnt);
        end
        wait_done(cyc);
        lat += cyc;
        checks++;
        if (!done || lat != 6) begin
            fails++; $display("FAIL fr_latency: got done=%b after %0d cycles expected 1 after 6", done, lat);
        end
        checks++;
        if (err_cnt !== 16'd3 || sum_ed !== 40'd65549 || max_ed !== 16'd65535) begin
            fails++; $display("FAIL fr_stats: got err=%0d sed=%0d max=%0d expected 3 65549 65535",
                              err_cnt, sum_ed, max_ed);
        end
        checks++;
        if (sum_err !== exp_err) begin
            fails++; $display("FAIL fr_sum_err: got %0d expected -65529", $signed(sum_err));
        end
    endtask

    task automatic test_bubbles;
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        start_run(16'd3);
        checks++;
        if (sum_ed !== '0 || max_ed !== '0 || err_cnt !== '0) begin
            fails++; $display("FAIL bub_clear: got sed=%0d max=%0d err=%0d expected 0 0 0", sum_ed, max_ed, err_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                checks++;
                if (in_ready !== 1'b1 || sample_cnt !== 16'd2) begin
                    fails++; $display("FAIL bub_mid: got ready=%b cnt=%0d expected 1 2", in_ready, sample_cnt);
                end
            end
            in_valid = pat[i]; prod_apx = 16'(i * 37); prod_exact = 16'(i * 37);
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL bub_ready_drop: got %b expected 0", in_ready);
        end
        in_valid = 1'b1; prod_apx = 16'd9; prod_exact = 16'd1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || sample_cnt !== 16'd3 || err_cnt !== '0 || sum_ed !== '0 || max_ed !== '0) begin
            fails++; $display("FAIL bub_stats: got done=%b cnt=%0d err=%0d sed=%0d max=%0d expected 1 3 0 0 0",
                              done, sample_cnt, err_cnt, sum_ed, max_ed);
        end
    endtask

    task automatic test_zero_and_ignore_start;
        int cyc;
        in_valid = 1'b1; prod_apx = 16'd50; prod_exact = 16'd10;
        start_run(16'd0);
        checks++;
        if ({done, busy, in_ready} !== 3'b100 || sample_cnt !== '0 || sum_ed !== '0 || sum_err !== '0) begin
            fails++; $display("FAIL zero_run: got done=%b busy=%b ready=%b cnt=%0d sed=%0d expected 1 0 0 0 0",
                              done, busy, in_ready, sample_cnt, sum_ed);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || sample_cnt !== '0 || sum_ed !== '0) begin
            fails++; $display("FAIL zero_hold: got ready=%b cnt=%0d sed=%0d expected 0 0 0", in_ready, sample_cnt, sum_ed);
        end
        in_valid = 1'b0;
        start_run(16'd5);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 3); n_samples = 16'd2;
            in_valid = 1'b1; prod_apx = 16'd5; prod_exact = 16'd3;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        wait_done(cyc);
        checks++;
        if (!done || sample_cnt !== 16'd5 || err_cnt !== 16'd5 || sum_ed !== 40'd10 || sum_err !== 40'd10 || max_ed !== 16'd2) begin
            fails++; $display("FAIL ignore_start: got done=%b cnt=%0d err=%0d sed=%0d serr=%0d max=%0d expected 1 5 5 10 10 2",
                              done, sample_cnt, err_cnt, sum_ed, sum_err, max_ed);
        end
        in_valid = 1'b1; prod_apx = 16'd99; prod_exact = 16'd1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (sample_cnt !== 16'd5 || sum_ed !== 40'd10 || max_ed !== 16'd2) begin
            fails++; $display("FAIL done_valid_ignored: got cnt=%0d sed=%0d max=%0d expected 5 10 2",
                              sample_cnt, sum_ed, max_ed);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        start_run(16'd1);
        checks++;
        if (sample_cnt !== '0 || err_cnt !== '0 || sum_ed !== '0 || sum_err !== '0 || max_ed !== '0 || done !== 1'b0) begin
            fails++; $display("FAIL b2b_clear: got cnt=%0d err=%0d sed=%0d serr=%0d max=%0d done=%b expected all 0",
                              sample_cnt, err_cnt, sum_ed, sum_err, max_ed, done);
        end
        in_valid = 1'b1; prod_apx = 16'd7; prod_exact = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(cyc);
        checks++;
        if (!done || sample_cnt !== 16'd1 || err_cnt !== 16'd1 || sum_ed !== 40'd2 || max_ed !== 16'd2) begin
            fails++; $display("FAIL b2b_stats: got done=%b cnt=%0d err=%0d sed=%0d max=%0d expected 1 1 1 2 2",
                              done, sample_cnt, err_cnt, sum_ed, max_ed);
        end
        checks++;
        if (sum_err !== 40'hFF_FFFF_FFFE) begin
            fails++; $display("FAIL b2b_sum_err: got %0d expected -2", $signed(sum_err));
        end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        start_run(16'd10);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; prod_apx = 16'd200; prod_exact = 16'd100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b000 || sample_cnt !== '0 || err_cnt !== '0 ||
            sum_ed !== '0 || sum_err !== '0 || max_ed !== '0) begin
            fails++; $display("FAIL midrun_reset: got ready=%b busy=%b done=%b cnt=%0d sed=%0d max=%0d expected all 0",
                              in_ready, busy, done, sample_cnt, sum_ed, max_ed);
        end
        @(negedge clk);
        rst = 1'b0;
        start_run(16'd2);
        in_valid = 1'b1; prod_apx = 16'd1; prod_exact = 16'd0;
        @(negedge clk);
        prod_apx = 16'd0; prod_exact = 16'd3;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(cyc);
        checks++;
        if (!done || sample_cnt !== 16'd2 || err_cnt !== 16'd2 || sum_ed !== 40'd4 ||
            sum_err !== 40'hFF_FFFF_FFFE || max_ed !== 16'd3) begin
            fails++; $display("FAIL post_reset_run: got done=%b cnt=%0d err=%0d sed=%0d serr=%0d max=%0d expected 1 2 2 4 -2 3",
                              done, sample_cnt, err_cnt, sum_ed, $signed(sum_err), max_ed);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_bubbles();
        test_zero_and_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
